// File: rtl/button_debouncer_bank_if.sv
// Bundle between raw button pins and the debounced event outputs of button_debouncer_bank.
// The master side is the debouncer; the slave side is the pin driver / event consumer.
interface button_debouncer_bank_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] button_in;
  logic [NUM_CH-1:0] button_level;
  logic [NUM_CH-1:0] press_pulse;
  logic [NUM_CH-1:0] release_pulse;
  logic [NUM_CH-1:0] repeat_pulse;
  logic              any_press;

  modport master (
    input  button_in,
    output button_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse,
    output any_press
  );

  modport slave (
    output button_in,
    input  button_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse,
    input  any_press
  );

endinterface

// File: rtl/button_debouncer_bank.sv
// Multi-channel button debouncer: synchroniser, stable-sample counter, press/release pulses.
// Define BUTTON_DEBOUNCER_AUTOREPEAT_EN to build the held-key auto-repeat generator.
module button_debouncer_bank #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int ACTIVE_LOW      = 0,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input logic                     clk,
  input logic                     reset,
  button_debouncer_bank_if.master bus
);

  function automatic int max_of(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int CNT_MAX = max_of(DEBOUNCE_CYCLES, max_of(HOLD_CYCLES, REPEAT_CYCLES));
`else
  localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [NUM_CH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
  logic [NUM_CH-1:0] samp_s;

  logic [NUM_CH-1:0] cand_r;
  logic [NUM_CH-1:0] cand_s;
  logic [CNT_W-1:0]  cnt_r [NUM_CH];
  logic [CNT_W-1:0]  cnt_s [NUM_CH];
  logic [NUM_CH-1:0] level_r;
  logic [NUM_CH-1:0] level_s;
  logic [NUM_CH-1:0] press_r;
  logic [NUM_CH-1:0] press_s;
  logic [NUM_CH-1:0] release_r;
  logic [NUM_CH-1:0] release_s;
  logic              any_press_r;

  // Polarity is normalised before the first stage so everything downstream is active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {NUM_CH{1'b0}};
      end
    end else begin
      sync_r[0] <= bus.button_in ^ POL_MASK;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign samp_s = sync_r[SYNC_STAGES-1];

  // Candidate tracking, saturating stable-sample count and level commit per channel.
  always_comb begin
    cand_s    = cand_r;
    level_s   = level_r;
    press_s   = {NUM_CH{1'b0}};
    release_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_s[i] = cnt_r[i];
      if (samp_s[i] != cand_r[i]) begin
        cand_s[i] = samp_s[i];
        cnt_s[i]  = CNT_ONE;
      end else if (cnt_r[i] < DEB_MAX) begin
        cnt_s[i] = cnt_r[i] + CNT_ONE;
      end else begin
        cnt_s[i] = cnt_r[i];
      end
      if ((samp_s[i] == cand_r[i]) && (cnt_r[i] == DEB_LAST) && (cand_r[i] != level_r[i])) begin
        level_s[i]   = cand_r[i];
        press_s[i]   = cand_r[i];
        release_s[i] = ~cand_r[i];
      end else begin
        level_s[i] = level_r[i];
      end
    end
  end

  // Debounce state and registered level/pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_r      <= {NUM_CH{1'b0}};
      level_r     <= {NUM_CH{1'b0}};
      press_r     <= {NUM_CH{1'b0}};
      release_r   <= {NUM_CH{1'b0}};
      any_press_r <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      cand_r      <= cand_s;
      level_r     <= level_s;
      press_r     <= press_s;
      release_r   <= release_s;
      any_press_r <= |press_s;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0]  hold_r [NUM_CH];
  logic [CNT_W-1:0]  hold_s [NUM_CH];
  logic [NUM_CH-1:0] phase_r;
  logic [NUM_CH-1:0] phase_s;
  logic [NUM_CH-1:0] repeat_r;
  logic [NUM_CH-1:0] repeat_s;

  // phase_r selects the initial hold interval (0) or the repeat period (1) as the reload target.
  always_comb begin
    repeat_s = {NUM_CH{1'b0}};
    phase_s  = phase_r;
    for (int i = 0; i < NUM_CH; i++) begin
      hold_s[i] = hold_r[i];
      if (press_s[i] || release_s[i] || !level_r[i]) begin
        hold_s[i]  = CNT_ZERO;
        phase_s[i] = 1'b0;
      end else if (hold_r[i] == (phase_r[i] ? REP_LAST : HOLD_LAST)) begin
        repeat_s[i] = 1'b1;
        hold_s[i]   = CNT_ZERO;
        phase_s[i]  = 1'b1;
      end else begin
        hold_s[i] = hold_r[i] + CNT_ONE;
      end
    end
  end

  // Hold counters and registered repeat pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r  <= {NUM_CH{1'b0}};
      repeat_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        hold_r[i] <= CNT_ZERO;
      end
    end else begin
      phase_r  <= phase_s;
      repeat_r <= repeat_s;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_r[i] <= hold_s[i];
      end
    end
  end

  assign bus.repeat_pulse = repeat_r;
`else
  logic unused_cfg_s;

  assign unused_cfg_s     = (HOLD_CYCLES > 0) ^ (REPEAT_CYCLES > 0);
  assign bus.repeat_pulse = {NUM_CH{1'b0}};
`endif

  assign bus.button_level  = level_r;
  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;
  assign bus.any_press     = any_press_r;

endmodule

// File: doc/button_debouncer_bank.md
Name: button_debouncer_bank

Overview:
Parametrised multi-channel successor to the single-button debouncer. Each of NUM_CH raw button/switch inputs is synchronised, debounced with a consecutive-stable-sample counter and given a clean level output plus one-cycle press and release pulses. It sits between the board pins and the UI/control FSMs. Optional auto-repeat supports held-key scrolling.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 100000, consecutive stable samples required before a level change (>=2)
ACTIVE_LOW, 0, 1 = pins are active-low; inverted before the synchroniser, so all internal and output logic is active-high
HOLD_CYCLES, 50000000, held duration before the first auto-repeat pulse (auto-repeat only, >=1)
REPEAT_CYCLES, 10000000, period between later auto-repeat pulses (auto-repeat only, >=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
button_in  in  NUM_CH  raw pin inputs, bit i = channel i, asynchronous to clk
button_level  out  NUM_CH  debounced pressed state (1 = pressed)
press_pulse  out  NUM_CH  one-cycle pulse on the debounced 0->1 transition
release_pulse  out  NUM_CH  one-cycle pulse on the debounced 1->0 transition
repeat_pulse  out  NUM_CH  auto-repeat pulses; constant 0 when the feature is compiled out
any_press  out  1  OR of press_pulse, registered in the same cycle as press_pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. Asserting reset clears every flop and output to 0: synchronisers, candidate, counters, button_level, all pulses and any_press. This includes reset mid-count or mid-hold, with no partial state retained. After reset deasserts, a held button is seen as a new press.
- Per channel i, all channels fully independent:
  - s = last synchroniser stage of (button_in[i] XOR ACTIVE_LOW).
  - cand = candidate value. cnt = count of consecutive samples equal to cand.
  - If s != cand: cand <= s and cnt <= 1.
  - Else if cnt < DEBOUNCE_CYCLES: cnt <= cnt + 1. cnt saturates at DEBOUNCE_CYCLES and never wraps.
  - When s == cand, cnt == DEBOUNCE_CYCLES-1 and cand != button_level: on that edge button_level[i] <= cand. On the same edge press_pulse[i] <= cand and release_pulse[i] <= ~cand. Both pulses are 0 on every other cycle.
- Latency: for a clean step on button_in, button_level changes on clock edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new pin value as edge 1.
- Any bounce shorter than DEBOUNCE_CYCLES samples restarts the count. No output activity results.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1) bits per channel.
- Simultaneous events on several channels produce pulses on all of them in the same cycle. any_press is asserted once for that cycle.
- press_pulse and release_pulse are never both high on one channel.

Optional Feature:
Macro BUTTON_DEBOUNCER_AUTOREPEAT_EN.
- Defined:
  - Each channel has a hold counter, cleared on the cycle press_pulse fires.
  - While button_level stays 1, the first repeat_pulse fires HOLD_CYCLES cycles after press_pulse. Further pulses fire every REPEAT_CYCLES cycles.
  - A release, or reset, clears the hold counter immediately. No repeat_pulse is emitted on or after the release edge.
  - repeat_pulse never coincides with press_pulse.
- Undefined:
  - No hold counters are synthesised.
  - repeat_pulse is tied to 0.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored, including in the counter width calculation.

Test Plan:
1. Clean press. NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ch1 steps 0->1. Required: button_level[1]=1 and press_pulse=4'b0010 for exactly one cycle on edge 6; any_press=1 on that cycle; other channels stay 0.
2. Bounce reject. Same config, ch0 pulses high for 3 samples, low for 1, then high steadily. Required: no level change during the glitch; level rises 6 edges after the final steady-high edge.
3. Simultaneous activity. ch0 released and ch3 pressed on the same cycle. Required: release_pulse=4'b0001 and press_pulse=4'b1000 in the same cycle; any_press=1.
4. Reset mid-count. Assert reset when cnt=2 during a press, hold 1 cycle, then release reset. Required: all outputs 0 immediately on reset; with the pin still high, a full 6-edge debounce restarts and press_pulse fires once.
5. ACTIVE_LOW=1. Pins idle 1 and go to 0 for the press. Required: button_level=0 while idle; press_pulse on the 1->0 pin step after 6 edges; release_pulse on the 0->1 step.
6. Auto-repeat, macro defined, HOLD_CYCLES=10, REPEAT_CYCLES=3. Hold ch2. Required: repeat_pulse[2] at press+10, +13, +16; release at press+17 yields no further repeat pulses. With the macro undefined, repeat_pulse stays 0 throughout.
